// File: rtl/batalha_pkg.sv
// rtl/batalha_pkg.sv - shared board constants, colisor FSM states and player encoding.
package batalha_pkg;
  localparam int NUM_LINHAS    = 11;
  localparam int LARGURA_LINHA = 64;
  localparam int LARGURA_ADDR  = 5;

  typedef enum logic [2:0] {
    IDLE,
    LEITURA,
    CHECA,
    ESCRITA,
    FIM
  } estado_colisor_t;

  typedef enum logic {
    JOGADOR_1 = 1'b0,
    JOGADOR_2 = 1'b1
  } jogador_t;
endpackage

// File: rtl/colisor_disparo_if.sv
// rtl/colisor_disparo_if.sv - shot request, colisor RMW port and result signals.
interface colisor_disparo_if;
  import batalha_pkg::*;

  logic                     disparo_valid;
  logic                     disparo_jogador;
  logic [3:0]               disparo_linha;
  logic [5:0]               disparo_coluna;
  logic                     ocupado;
  logic                     readyColisor;
  logic                     jogadorColisor;
  logic [LARGURA_ADDR-1:0]  colisor_addr;
  logic [LARGURA_LINHA-1:0] dataReadColisor;
  logic                     colisor_wrep1;
  logic                     colisor_wrep2;
  logic [LARGURA_LINHA-1:0] colisor_data;
  logic                     resultado_valid;
  logic                     acerto;
  logic                     invalido;
  logic [6:0]               acertos_p1;
  logic [6:0]               acertos_p2;

  modport master (
    input  disparo_valid, disparo_jogador, disparo_linha, disparo_coluna, dataReadColisor,
    output ocupado, readyColisor, jogadorColisor, colisor_addr, colisor_wrep1, colisor_wrep2,
    output colisor_data, resultado_valid, acerto, invalido, acertos_p1, acertos_p2
  );

  modport slave (
    output disparo_valid, disparo_jogador, disparo_linha, disparo_coluna, dataReadColisor,
    input  ocupado, readyColisor, jogadorColisor, colisor_addr, colisor_wrep1, colisor_wrep2,
    input  colisor_data, resultado_valid, acerto, invalido, acertos_p1, acertos_p2
  );
endinterface

// File: rtl/contador_acertos.sv
// rtl/contador_acertos.sv - 7-bit saturating hit counter with sync clear.
module contador_acertos (
  input  logic       clk,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [6:0] o_valor
);
  logic [6:0] r_valor;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_valor <= 7'd0;
    end else if (i_inc && (r_valor != 7'h7f)) begin
      r_valor <= r_valor + 7'd1;
    end
  end

  assign o_valor = r_valor;
endmodule

// File: rtl/colisor_disparo.sv
// rtl/colisor_disparo.sv - resolves one shot via read-modify-write on the colisor port.
module colisor_disparo #(
  parameter int LAT_LEITURA = 2,
  parameter int NUM_LINHAS  = batalha_pkg::NUM_LINHAS
) (
  input  logic                clk,
  input  logic                resetGeral,
  colisor_disparo_if.master   bus
);
  import batalha_pkg::*;

  localparam logic [2:0] CNT_INI = 3'(LAT_LEITURA - 1);

  estado_colisor_t          r_estado;
  logic [2:0]               r_cnt;
  jogador_t                 r_jog;
  logic [5:0]               r_col;
  logic [LARGURA_ADDR-1:0]  r_addr;
  logic [LARGURA_LINHA-1:0] r_linha_dado;
  logic [LARGURA_LINHA-1:0] r_data;
  logic                     r_hit;
  logic                     r_ready;
  logic                     r_wrep1;
  logic                     r_wrep2;
  logic                     r_rv;
  logic                     r_acerto;
  logic                     r_invalido;

  logic                     w_linha_invalida;
  logic                     w_bit_hit;
  logic                     w_wrep1;
  logic                     w_wrep2;
  logic [6:0]               w_acertos_p1;
  logic [6:0]               w_acertos_p2;

  assign w_linha_invalida = ({1'b0, bus.disparo_linha} >= 5'(NUM_LINHAS));
  assign w_bit_hit        = r_linha_dado[r_col];

  // A reset landing in the ESCRITA cycle must kill the strobe already on the wire.
  assign w_wrep1 = r_wrep1 & ~resetGeral;
  assign w_wrep2 = r_wrep2 & ~resetGeral;

  always_ff @(posedge clk) begin
    if (resetGeral) begin
      r_estado     <= IDLE;
      r_cnt        <= 3'd0;
      r_jog        <= JOGADOR_1;
      r_col        <= 6'd0;
      r_addr       <= '0;
      r_linha_dado <= '0;
      r_data       <= '0;
      r_hit        <= 1'b0;
      r_ready      <= 1'b0;
      r_wrep1      <= 1'b0;
      r_wrep2      <= 1'b0;
      r_rv         <= 1'b0;
      r_acerto     <= 1'b0;
      r_invalido   <= 1'b0;
    end else begin
      r_wrep1 <= 1'b0;
      r_wrep2 <= 1'b0;
      r_rv    <= 1'b0;
      case (r_estado)
        IDLE: begin
          if (bus.disparo_valid) begin
            r_col <= bus.disparo_coluna;
            if (w_linha_invalida) begin
              r_estado   <= FIM;
              r_rv       <= 1'b1;
              r_invalido <= 1'b1;
              r_acerto   <= 1'b0;
            end else begin
              r_estado <= LEITURA;
              r_jog    <= jogador_t'(bus.disparo_jogador);
              r_addr   <= {1'b0, bus.disparo_linha};
              r_ready  <= 1'b1;
              r_cnt    <= CNT_INI;
            end
          end
        end
        LEITURA: begin
          if (r_cnt == 3'd0) begin
            r_linha_dado <= bus.dataReadColisor;
            r_estado     <= CHECA;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        CHECA: begin
          r_hit    <= w_bit_hit;
          r_data   <= r_linha_dado & ~(64'h1 << r_col);
          r_wrep1  <= w_bit_hit && (r_jog == JOGADOR_1);
          r_wrep2  <= w_bit_hit && (r_jog == JOGADOR_2);
          r_estado <= ESCRITA;
        end
        ESCRITA: begin
          r_ready    <= 1'b0;
          r_rv       <= 1'b1;
          r_acerto   <= r_hit;
          r_invalido <= 1'b0;
          r_estado   <= FIM;
        end
        FIM:     r_estado <= IDLE;
        default: r_estado <= IDLE;
      endcase
    end
  end

  contador_acertos u_cont_p1 (
    .clk     (clk),
    .i_clr   (resetGeral),
    .i_inc   (w_wrep1),
    .o_valor (w_acertos_p1)
  );

  contador_acertos u_cont_p2 (
    .clk     (clk),
    .i_clr   (resetGeral),
    .i_inc   (w_wrep2),
    .o_valor (w_acertos_p2)
  );

  assign bus.ocupado         = (r_estado != IDLE);
  assign bus.readyColisor    = r_ready;
  assign bus.jogadorColisor  = r_jog;
  assign bus.colisor_addr    = r_addr;
  assign bus.colisor_wrep1   = w_wrep1;
  assign bus.colisor_wrep2   = w_wrep2;
  assign bus.colisor_data    = r_data;
  assign bus.resultado_valid = r_rv;
  assign bus.acerto          = r_acerto;
  assign bus.invalido        = r_invalido;
  assign bus.acertos_p1      = w_acertos_p1;
  assign bus.acertos_p2      = w_acertos_p2;
endmodule

// File: tb/tb_colisor_disparo.sv
// tb/tb_colisor_disparo.sv - directed bench for colisor_disparo with a colisor-port memory model.
module tb_colisor_disparo;
  import batalha_pkg::*;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic resetGeral;
  int   errors = 0;
  int   checks = 0;
  int   rd_cnt = 0;
  logic [63:0] mem1 [0:31];
  logic [63:0] mem2 [0:31];

  always #5 clk = ~clk;

  colisor_disparo_if bus ();

  colisor_disparo #(.LAT_LEITURA(LAT), .NUM_LINHAS(11)) dut (
    .clk        (clk),
    .resetGeral (resetGeral),
    .bus        (bus)
  );

  // Controller model: row data is valid only in the LAT-th ready cycle, garbage otherwise.
  always @(posedge clk) rd_cnt <= bus.readyColisor ? rd_cnt + 1 : 0;

  always_comb begin
    bus.dataReadColisor = 64'hA5A5_A5A5_A5A5_A5A5;
    if (bus.readyColisor && rd_cnt == LAT - 1)
      bus.dataReadColisor = bus.jogadorColisor ? mem2[bus.colisor_addr] : mem1[bus.colisor_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_shot(input logic j, input logic [3:0] l, input logic [5:0] c,
                         input logic exp_hit, input logic exp_inv,
                         input logic [63:0] exp_wdata, input logic poke);
    bus.disparo_valid   = 1'b1;
    bus.disparo_jogador = j;
    bus.disparo_linha   = l;
    bus.disparo_coluna  = c;
    tick();
    bus.disparo_valid = 1'b0;
    if (exp_inv) begin
      chk("inv_rv", bus.resultado_valid, 1);
      chk("inv_flag", bus.invalido, 1);
      chk("inv_acerto", bus.acerto, 0);
      chk("inv_ready", bus.readyColisor, 0);
      chk("inv_wrep", {bus.colisor_wrep1, bus.colisor_wrep2}, 0);
      tick();
      chk("inv_ready2", bus.readyColisor, 0);
    end else begin
      for (int k = 1; k <= LAT + 3; k++) begin
        if (poke && k == 1) begin
          bus.disparo_valid   = 1'b1;
          bus.disparo_linha   = 4'd12;
          bus.disparo_jogador = ~j;
        end else begin
          bus.disparo_valid = 1'b0;
        end
        chk("ready", bus.readyColisor, (k <= LAT + 2));
        chk("ocupado", bus.ocupado, 1);
        chk("wrep1", bus.colisor_wrep1, (exp_hit && !j && k == LAT + 2));
        chk("wrep2", bus.colisor_wrep2, (exp_hit && j && k == LAT + 2));
        chk("rv", bus.resultado_valid, (k == LAT + 3));
        if (k <= LAT + 2) begin
          chk("addr", bus.colisor_addr, {1'b0, l});
          chk("jog", bus.jogadorColisor, j);
        end
        if (k == LAT + 2 && exp_hit) chk("wdata", bus.colisor_data, exp_wdata);
        if (k == LAT + 3) begin
          chk("acerto", bus.acerto, exp_hit);
          chk("invalido", bus.invalido, 0);
        end
        tick();
      end
      if (exp_hit) begin
        if (j) mem2[l] = exp_wdata;
        else   mem1[l] = exp_wdata;
      end
    end
    chk("end_ocupado", bus.ocupado, 0);
    chk("end_rv", bus.resultado_valid, 0);
    chk("hold_acerto", bus.acerto, exp_hit && !exp_inv);
    chk("hold_invalido", bus.invalido, exp_inv);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      mem1[r] = 64'h0;
      mem2[r] = 64'h0;
    end
    bus.disparo_valid   = 1'b0;
    bus.disparo_jogador = 1'b0;
    bus.disparo_linha   = 4'd0;
    bus.disparo_coluna  = 6'd0;
    resetGeral = 1'b1;
    tick();
    tick();
    chk("rst_ocupado", bus.ocupado, 0);
    chk("rst_ready", bus.readyColisor, 0);
    chk("rst_rv", bus.resultado_valid, 0);
    chk("rst_data", bus.colisor_data, 0);
    chk("rst_cnt", {bus.acertos_p1, bus.acertos_p2}, 0);
    resetGeral = 1'b0;
    tick();

    mem1[3] = 64'h0000_0000_0000_0010;
    do_shot(1'b0, 4'd3, 6'd4, 1'b1, 1'b0, 64'h0, 1'b0);
    chk("hit_p1_cnt", bus.acertos_p1, 1);

    do_shot(1'b0, 4'd3, 6'd4, 1'b0, 1'b0, 64'h0, 1'b0);
    chk("miss_p1_cnt", bus.acertos_p1, 1);

    mem2[10] = 64'h8000_0000_0000_0001;
    do_shot(1'b1, 4'd10, 6'd63, 1'b1, 1'b0, 64'h0000_0000_0000_0001, 1'b0);
    chk("p2_cnt", bus.acertos_p2, 1);
    chk("p2_p1_cnt", bus.acertos_p1, 1);

    do_shot(1'b0, 4'd11, 6'd0, 1'b0, 1'b1, 64'h0, 1'b0);
    do_shot(1'b1, 4'd15, 6'd5, 1'b0, 1'b1, 64'h0, 1'b0);
    chk("inv_cnt", {bus.acertos_p1, bus.acertos_p2}, {7'd1, 7'd1});

    mem1[5] = 64'h1;
    do_shot(1'b0, 4'd5, 6'd0, 1'b1, 1'b0, 64'h0, 1'b1);
    tick();
    chk("busy_not_queued", bus.ocupado, 0);
    chk("busy_cnt", bus.acertos_p1, 2);

    for (int r = 0; r < 11; r++) mem1[r] = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 130; i++) begin
      logic [3:0]  row;
      logic [5:0]  col;
      logic [63:0] wd;
      row = 4'(i % 11);
      col = 6'(i / 11);
      wd  = mem1[row] & ~(64'h1 << col);
      do_shot(1'b0, row, col, 1'b1, 1'b0, wd, 1'b0);
      chk("sat_cnt", bus.acertos_p1, (i + 3 > 127) ? 127 : i + 3);
    end
    chk("sat_final", bus.acertos_p1, 127);
    chk("sat_p2", bus.acertos_p2, 1);

    mem1[7] = 64'h4;
    bus.disparo_valid   = 1'b1;
    bus.disparo_jogador = 1'b0;
    bus.disparo_linha   = 4'd7;
    bus.disparo_coluna  = 6'd2;
    tick();
    bus.disparo_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("rst_pre_wrep1", bus.colisor_wrep1, 1);
    resetGeral = 1'b1;
    #1;
    chk("rst_kill_wrep1", bus.colisor_wrep1, 0);
    chk("rst_kill_wrep2", bus.colisor_wrep2, 0);
    tick();
    chk("rstmid_rv", bus.resultado_valid, 0);
    chk("rstmid_ocupado", bus.ocupado, 0);
    chk("rstmid_ready", bus.readyColisor, 0);
    chk("rstmid_flags", {bus.acerto, bus.invalido, bus.jogadorColisor}, 0);
    chk("rstmid_addr", bus.colisor_addr, 0);
    chk("rstmid_data", bus.colisor_data, 0);
    chk("rstmid_cnt", {bus.acertos_p1, bus.acertos_p2}, 0);
    resetGeral = 1'b0;
    tick();
    chk("rstmid_no_result", bus.resultado_valid, 0);
    chk("rstmid_wrep", {bus.colisor_wrep1, bus.colisor_wrep2}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/colisor_disparo.md
# colisor_disparo

Shot-resolution client for the board memory controller (`ControladoMemoria`). It accepts one shot (target player, row, column), reads the target row through the controller's colisor port, and tests the addressed bit. On a hit it writes the row back with that bit cleared. It then reports hit/miss/invalid and keeps a saturating hit tally per player. It is the initiator at the other end of the controller's colisor read-modify-write port.

## Interface
Parameters:
- `LAT_LEITURA`, 2: cycles from first `readyColisor` cycle to valid `dataReadColisor`; legal range 1..7.
- `NUM_LINHAS`, 11: board rows; legal rows 0..NUM_LINHAS-1.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `resetGeral`  in  1  synchronous, active-high reset.
- `disparo_valid`  in  1  shot request; accepted only while `ocupado`=0.
- `disparo_jogador`  in  1  target board: 0 = player 1, 1 = player 2.
- `disparo_linha`  in  4  target row.
- `disparo_coluna`  in  6  target column = bit index in row word.
- `ocupado`  out  1  busy; high from the cycle after accept until `resultado_valid` inclusive.
- `readyColisor`  out  1  colisor port request to controller.
- `jogadorColisor`  out  1  board select to controller.
- `colisor_addr`  out  5  row address, zero-extended `disparo_linha`.
- `dataReadColisor`  in  64  row data returned by controller.
- `colisor_wrep1` / `colisor_wrep2`  out  1 each  write strobe for player 1 / player 2 board.
- `colisor_data`  out  64  write-back row.
- `resultado_valid`  out  1  one-cycle result strobe.
- `acerto`  out  1  hit; valid with `resultado_valid`.
- `invalido`  out  1  row out of range; valid with `resultado_valid`.
- `acertos_p1` / `acertos_p2`  out  7 each  hits landed on player 1 / player 2 board; saturate at 127.

## Operation
- Board encoding: bit = 1 means ship cell intact. A hit clears the bit to 0. Re-shooting a cleared cell is a miss, with no write.
- FSM states: IDLE, LEITURA, CHECA, ESCRITA, FIM.
- IDLE: `disparo_valid`=1 latches jogador, linha and coluna.
  - If `disparo_linha` >= NUM_LINHAS, go to FIM with `invalido`=1. No port activity.
  - Otherwise go to LEITURA.
- LEITURA: `readyColisor`=1 with address and player stable. A down-counter runs LAT_LEITURA cycles. `dataReadColisor` is registered on the last cycle; then go to CHECA.
- CHECA: hit = row[coluna]. Compute new row = row & ~(1 << coluna) into `colisor_data`. Go to ESCRITA.
- ESCRITA: on a hit, pulse exactly one write strobe for one cycle: `colisor_wrep1` if jogador=0, else `colisor_wrep2`. Increment the matching counter, saturating at 127. On a miss, issue no strobe. Go to FIM.
- FIM: `resultado_valid`=1 for one cycle, with `acerto`/`invalido`. Return to IDLE.
- `acerto` and `invalido` hold their value until the next result. `invalido`=1 forces `acerto`=0.
- `disparo_valid` while `ocupado`=1 is ignored and not queued.

## Timing
- Accept cycle A is an IDLE cycle with `disparo_valid`=1.
- `readyColisor`=1 in cycles A+1 through A+LAT_LEITURA+2, then 0.
- Data is sampled at the end of cycle A+LAT_LEITURA.
- Write strobe, if any, occurs in cycle A+LAT_LEITURA+2.
- `resultado_valid` occurs in cycle A+LAT_LEITURA+3. This latency is fixed for hit and miss.
- Invalid row: `resultado_valid` in cycle A+1, and `readyColisor` never rises.
- Back-to-back: the earliest next accept is the cycle after `resultado_valid`.
- Write strobes are never asserted while `readyColisor`=0. `colisor_wrep1` and `colisor_wrep2` are never high together.
- Reset values: all outputs 0, `colisor_data`=0, counters 0, FSM in IDLE.
- `resetGeral` mid-operation: the next cycle is IDLE with all outputs 0. A write scheduled in the reset cycle is suppressed. No result is reported.

## Structure
- Shared package `batalha_pkg`:
  - constants `NUM_LINHAS`=11, `LARGURA_LINHA`=64, `LARGURA_ADDR`=5;
  - the colisor FSM state enum;
  - the player encoding (0 = player 1).
- Sub-module `contador_acertos`: 7-bit saturating counter with sync clear and increment enable. It is instantiated twice.
- The rest is one FSM plus datapath registers.

## Test plan
- Hit: P1 board row 3 = 64'h0000_0000_0000_0010, shot (0,3,4), LAT=2 → `colisor_wrep1` at A+4 with `colisor_data`=64'h0; `resultado_valid`, `acerto`=1 at A+5; `acertos_p1`=1.
- Miss/repeat: repeat the same shot → no strobe, `acerto`=0 at A+5, `acertos_p1` stays 1.
- Player 2 high bit: P2 row 10 = 64'h8000_0000_0000_0001, shot (1,10,63) → `colisor_wrep2` with 64'h0000_0000_0000_0001; `colisor_wrep1` stays 0.
- Invalid row: shot row 11 → `invalido`=1 at A+1; `readyColisor` and both strobes never assert.
- Busy/saturation: issue `disparo_valid` during a busy transaction → ignored. Run 130 hits on P1 → `acertos_p1`=127.
- Reset: assert `resetGeral` in cycle A+LAT+2 of a hit → no strobe, no `resultado_valid`, all outputs 0 the next cycle.
